// File: rtl/player_pkg.sv
// Shared state encodings, tile constants and grid helpers for the player motion controller.
// Pure definitions; no latency, no handshake.
package player_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_SKIP,
        S_QX,
        S_QY,
        S_QXY,
        S_COMMIT,
        S_DONE
    } state_t;

    localparam int TILE_EMPTY = 0;

    function automatic int unsigned pos_to_cell(input int unsigned pos, input int unsigned shift);
        return pos >> shift;
    endfunction

endpackage

// File: rtl/player_grid_probe.sv
// Single map-cell query: one-cycle grid_req, then waits any number of cycles for grid_valid.
// o_done pulses with grid_valid; cell coordinates stay held until the next i_start.
module player_grid_probe
    import player_pkg::*;
#(
    parameter int GX_W   = 6,
    parameter int GY_W   = 5,
    parameter int TILE_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic [GX_W-1:0]   i_cell_x,
    input  logic [GY_W-1:0]   i_cell_y,
    output logic              o_done,
    output logic              o_free,
    output logic              grid_req,
    output logic [GX_W-1:0]   grid_x,
    output logic [GY_W-1:0]   grid_y,
    input  logic              grid_valid,
    input  logic [TILE_W-1:0] grid_out
);

    logic            r_req;
    logic            r_wait;
    logic [GX_W-1:0] r_gx;
    logic [GY_W-1:0] r_gy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req  <= 1'b0;
            r_wait <= 1'b0;
            r_gx   <= '0;
            r_gy   <= '0;
        end else begin
            r_req <= i_start;
            if (i_start) begin
                r_wait <= 1'b1;
                r_gx   <= i_cell_x;
                r_gy   <= i_cell_y;
            end else if (grid_valid) begin
                r_wait <= 1'b0;
            end
        end
    end

    // A grid_valid arriving while not waiting (e.g. after a reset) is ignored.
    assign o_done   = r_wait & grid_valid;
    assign o_free   = (grid_out == TILE_W'(TILE_EMPTY));
    assign grid_req = r_req;
    assign grid_x   = r_gx;
    assign grid_y   = r_gy;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-start player pose update (turn + per-axis collision slide), rate-limited by a tick divider.
// start->done: 2 cycles when skipped, else EVAL/queries/COMMIT/DONE; PLAYER_STRAFE_EN adds strafe keys.
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int X_W        = 14,
    parameter int Y_W        = 13,
    parameter int ANG_W      = 8,
    parameter int CELL_SHIFT = 8,
    parameter int GX_W       = 6,
    parameter int GY_W       = 5,
    parameter int TILE_W     = 3,
    parameter int TURN_STEP  = 10,
    parameter int TICK_DIV   = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    input  logic              turn_right,
    input  logic              turn_left,
    input  logic              move_forward,
    input  logic              move_backward,
`ifdef PLAYER_STRAFE_EN
    input  logic              strafe_left,
    input  logic              strafe_right,
`endif
    input  logic [X_W-1:0]    cur_pos_x,
    input  logic [Y_W-1:0]    cur_pos_y,
    input  logic [ANG_W-1:0]  cur_angle,
    input  logic [X_W:0]      dir_x,
    input  logic [Y_W:0]      dir_y,
    output logic              grid_req,
    output logic [GX_W-1:0]   grid_x,
    output logic [GY_W-1:0]   grid_y,
    input  logic              grid_valid,
    input  logic [TILE_W-1:0] grid_out,
    output logic [X_W-1:0]    next_pos_x,
    output logic [Y_W-1:0]    next_pos_y,
    output logic [ANG_W-1:0]  next_angle
);

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TICK_DIV - 1);
    localparam logic [ANG_W-1:0]  TURN_INC = ANG_W'(TURN_STEP);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic [X_W-1:0]     r_cand_x, r_next_x;
    logic [Y_W-1:0]     r_cand_y, r_next_y;
    logic [ANG_W-1:0]   r_cand_ang, r_next_ang, w_cand_ang;
    logic               r_mv_x, r_mv_y, r_oob_x, r_oob_y;
    logic               r_fx, r_fy, r_fxy, r_issued;

    logic signed [X_W+1:0] w_cur_x_ext, w_dir_x_ext, w_step_x, w_cand_x;
    logic signed [Y_W+1:0] w_cur_y_ext, w_dir_y_ext, w_step_y, w_cand_y;
    logic                  w_fwd, w_bwd;

    logic [GX_W-1:0] w_cx_cand, w_cx_cur, w_q_cx;
    logic [GY_W-1:0] w_cy_cand, w_cy_cur, w_q_cy;
    logic            w_in_q, w_need_q, w_skip_free, w_q_adv, w_q_res;
    logic            w_probe_start, w_probe_done, w_probe_free;

    assign w_fwd       = move_forward & ~move_backward;
    assign w_bwd       = move_backward & ~move_forward;
    assign w_cur_x_ext = {2'b00, cur_pos_x};
    assign w_cur_y_ext = {2'b00, cur_pos_y};
    assign w_dir_x_ext = {dir_x[X_W], dir_x};
    assign w_dir_y_ext = {dir_y[Y_W], dir_y};

`ifdef PLAYER_STRAFE_EN
    logic signed [X_W+1:0] w_str_x;
    logic signed [Y_W+1:0] w_str_y;
    assign w_str_x = (X_W+2)'($signed(dir_y));
    assign w_str_y = (Y_W+2)'($signed(dir_x));
`endif

    always_comb begin
        w_step_x = '0;
        w_step_y = '0;
        if (w_fwd) begin
            w_step_x = w_dir_x_ext;
            w_step_y = w_dir_y_ext;
        end else if (w_bwd) begin
            w_step_x = -w_dir_x_ext;
            w_step_y = -w_dir_y_ext;
        end
`ifdef PLAYER_STRAFE_EN
        // Right strafe is the perpendicular (dir_y, -dir_x); left is its negation.
        if (strafe_right & ~strafe_left) begin
            w_step_x = w_step_x + w_str_x;
            w_step_y = w_step_y - w_str_y;
        end else if (strafe_left & ~strafe_right) begin
            w_step_x = w_step_x - w_str_x;
            w_step_y = w_step_y + w_str_y;
        end
`endif
    end

    assign w_cand_x   = w_cur_x_ext + w_step_x;
    assign w_cand_y   = w_cur_y_ext + w_step_y;
    assign w_cand_ang = (turn_right & ~turn_left) ? cur_angle + TURN_INC :
                        (turn_left & ~turn_right) ? cur_angle - TURN_INC : cur_angle;

    assign w_cx_cand = GX_W'(pos_to_cell(32'(r_cand_x), CELL_SHIFT));
    assign w_cy_cand = GY_W'(pos_to_cell(32'(r_cand_y), CELL_SHIFT));
    assign w_cx_cur  = GX_W'(pos_to_cell(32'(cur_pos_x), CELL_SHIFT));
    assign w_cy_cur  = GY_W'(pos_to_cell(32'(cur_pos_y), CELL_SHIFT));

    // Zero-step axes are free without a query; out-of-bounds axes are blocked without one.
    always_comb begin
        w_in_q      = 1'b0;
        w_need_q    = 1'b0;
        w_skip_free = 1'b0;
        w_q_cx      = w_cx_cur;
        w_q_cy      = w_cy_cur;
        case (r_state)
            S_QX: begin
                w_in_q      = 1'b1;
                w_need_q    = r_mv_x & ~r_oob_x;
                w_skip_free = ~r_mv_x;
                w_q_cx      = w_cx_cand;
            end
            S_QY: begin
                w_in_q      = 1'b1;
                w_need_q    = r_mv_y & ~r_oob_y;
                w_skip_free = ~r_mv_y;
                w_q_cy      = w_cy_cand;
            end
            S_QXY: begin
                w_in_q      = 1'b1;
                w_need_q    = r_fx & r_fy & r_mv_x & r_mv_y;
                w_skip_free = r_fx & r_fy;
                w_q_cx      = w_cx_cand;
                w_q_cy      = w_cy_cand;
            end
            default: ;
        endcase
    end

    assign w_probe_start = w_need_q & ~r_issued;
    assign w_q_adv       = w_in_q & (~w_need_q | w_probe_done);
    assign w_q_res       = w_need_q ? w_probe_free : w_skip_free;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = (r_tick_cnt == '0) ? S_EVAL : S_SKIP;
            S_EVAL:   w_state_nxt = (w_step_x == '0 && w_step_y == '0) ? S_COMMIT : S_QX;
            S_SKIP:   w_state_nxt = S_DONE;
            S_QX:     if (w_q_adv) w_state_nxt = S_QY;
            S_QY:     if (w_q_adv) w_state_nxt = S_QXY;
            S_QXY:    if (w_q_adv) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_cand_x   <= '0;
            r_cand_y   <= '0;
            r_cand_ang <= '0;
            r_mv_x     <= 1'b0;
            r_mv_y     <= 1'b0;
            r_oob_x    <= 1'b0;
            r_oob_y    <= 1'b0;
            r_fx       <= 1'b0;
            r_fy       <= 1'b0;
            r_fxy      <= 1'b0;
            r_issued   <= 1'b0;
            r_next_x   <= '0;
            r_next_y   <= '0;
            r_next_ang <= '0;
        end else begin
            if (r_state == S_IDLE && start && r_tick_cnt == '0) r_tick_cnt <= CNT_LOAD;
            else if (r_tick_cnt != '0)                          r_tick_cnt <= r_tick_cnt - 1'b1;

            if (w_q_adv)            r_issued <= 1'b0;
            else if (w_probe_start) r_issued <= 1'b1;

            case (r_state)
                S_EVAL: begin
                    r_cand_x   <= w_cand_x[X_W-1:0];
                    r_cand_y   <= w_cand_y[Y_W-1:0];
                    r_cand_ang <= w_cand_ang;
                    r_oob_x    <= w_cand_x[X_W+1] | w_cand_x[X_W];
                    r_oob_y    <= w_cand_y[Y_W+1] | w_cand_y[Y_W];
                    r_mv_x     <= (w_step_x != '0);
                    r_mv_y     <= (w_step_y != '0);
                    r_fx       <= 1'b0;
                    r_fy       <= 1'b0;
                    r_fxy      <= 1'b0;
                end
                S_SKIP: begin
                    r_next_x   <= cur_pos_x;
                    r_next_y   <= cur_pos_y;
                    r_next_ang <= cur_angle;
                end
                S_QX:  if (w_q_adv) r_fx  <= w_q_res;
                S_QY:  if (w_q_adv) r_fy  <= w_q_res;
                S_QXY: if (w_q_adv) r_fxy <= w_q_res;
                S_COMMIT: begin
                    r_next_ang <= r_cand_ang;
                    r_next_x   <= cur_pos_x;
                    r_next_y   <= cur_pos_y;
                    if (r_fx & r_fy & r_fxy) begin
                        r_next_x <= r_cand_x;
                        r_next_y <= r_cand_y;
                    end else if (r_fx) begin
                        r_next_x <= r_cand_x;
                    end else if (r_fy) begin
                        r_next_y <= r_cand_y;
                    end
                end
                default: ;
            endcase
        end
    end

    player_grid_probe #(
        .GX_W   (GX_W),
        .GY_W   (GY_W),
        .TILE_W (TILE_W)
    ) u_probe (
        .clock      (clock),
        .reset      (reset),
        .i_start    (w_probe_start),
        .i_cell_x   (w_q_cx),
        .i_cell_y   (w_q_cy),
        .o_done     (w_probe_done),
        .o_free     (w_probe_free),
        .grid_req   (grid_req),
        .grid_x     (grid_x),
        .grid_y     (grid_y),
        .grid_valid (grid_valid),
        .grid_out   (grid_out)
    );

    assign done       = (r_state == S_DONE);
    assign next_pos_x = r_next_x;
    assign next_pos_y = r_next_y;
    assign next_angle = r_next_ang;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with a behavioural grid memory (one optional wall cell).
module tb_player_motion_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic        turn_right = 1'b0, turn_left = 1'b0, move_forward = 1'b0, move_backward = 1'b0;
    logic [13:0] cur_pos_x = '0;
    logic [12:0] cur_pos_y = '0;
    logic [7:0]  cur_angle = '0;
    logic [14:0] dir_x = '0;
    logic [13:0] dir_y = '0;
    logic        grid_req;
    logic [5:0]  grid_x;
    logic [4:0]  grid_y;
    logic        grid_valid = 1'b0;
    logic [2:0]  grid_out = '0;
    logic [13:0] next_pos_x;
    logic [12:0] next_pos_y;
    logic [7:0]  next_angle;

    int n_cmp = 0;
    int n_err = 0;
    int req_count = 0;
    int grid_lat = 1;
    int wait_cnt = 0;
    bit pend = 0;
    int qx = 0, qy = 0;
    bit wall_en = 0;
    int wall_cx = 0, wall_cy = 0;
    int lat;

    player_motion_ctrl #(.TICK_DIV(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .done          (done),
        .turn_right    (turn_right),
        .turn_left     (turn_left),
        .move_forward  (move_forward),
        .move_backward (move_backward),
        .cur_pos_x     (cur_pos_x),
        .cur_pos_y     (cur_pos_y),
        .cur_angle     (cur_angle),
        .dir_x         (dir_x),
        .dir_y         (dir_y),
        .grid_req      (grid_req),
        .grid_x        (grid_x),
        .grid_y        (grid_y),
        .grid_valid    (grid_valid),
        .grid_out      (grid_out),
        .next_pos_x    (next_pos_x),
        .next_pos_y    (next_pos_y),
        .next_angle    (next_angle)
    );

    always #5 clock = ~clock;

    // Grid memory: answers each grid_req after grid_lat cycles.
    always @(posedge clock) begin
        #1;
        grid_valid = 1'b0;
        if (pend) begin
            if (wait_cnt <= 1) begin
                grid_valid = 1'b1;
                grid_out   = (wall_en && qx == wall_cx && qy == wall_cy) ? 3'd5 : 3'd0;
                pend       = 0;
            end else begin
                wait_cnt--;
            end
        end
        if (grid_req) begin
            pend     = 1;
            wait_cnt = grid_lat;
            qx       = int'(grid_x);
            qy       = int'(grid_y);
            req_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pose(input int x, input int y, input int a, input int dx, input int dy);
        cur_pos_x = 14'(x);
        cur_pos_y = 13'(y);
        cur_angle = 8'(a);
        dir_x     = 15'(dx);
        dir_y     = 14'(dy);
    endtask

    task automatic set_keys(input logic r, input logic l, input logic f, input logic b);
        turn_right    = r;
        turn_left     = l;
        move_forward  = f;
        move_backward = b;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic run_start(input string tag, output int cyc);
        req_count = 0;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_done", 32'(done), 0);
        chk("rst_req", 32'(grid_req), 0);
        chk("rst_gx", 32'(grid_x), 0);
        chk("rst_gy", 32'(grid_y), 0);
        chk("rst_nx", 32'(next_pos_x), 0);
        chk("rst_ny", 32'(next_pos_y), 0);
        chk("rst_na", 32'(next_angle), 0);
        reset = 1'b0;

        // Free diagonal move, all cells empty, grid latency 3.
        grid_lat = 3;
        set_pose(1000, 1000, 0, 40, 20);
        set_keys(0, 0, 1, 0);
        run_start("free", lat);
        chk("free_x", 32'(next_pos_x), 1040);
        chk("free_y", 32'(next_pos_y), 1020);
        chk("free_a", 32'(next_angle), 0);
        chk("free_reqs", 32'(req_count), 3);

        // Wall at cell (4,3): x blocked, y slides.
        idle(12);
        grid_lat = 1;
        wall_en = 1; wall_cx = 4; wall_cy = 3;
        set_pose(1020, 1000, 0, 40, 20);
        run_start("slide", lat);
        chk("slide_x", 32'(next_pos_x), 1020);
        chk("slide_y", 32'(next_pos_y), 1020);
        chk("slide_reqs", 32'(req_count), 2);

        // Only the diagonal cell (4,4) is a wall: x-only move.
        idle(12);
        wall_cx = 4; wall_cy = 4;
        set_pose(1000, 1000, 0, 40, 40);
        run_start("corner", lat);
        chk("corner_x", 32'(next_pos_x), 1040);
        chk("corner_y", 32'(next_pos_y), 1000);
        chk("corner_reqs", 32'(req_count), 3);

        // Turning only: wrap, cancel, and left turn below zero.
        idle(12);
        wall_en = 0;
        set_pose(500, 600, 250, 40, 20);
        set_keys(1, 0, 0, 0);
        run_start("turn_r", lat);
        chk("turn_r_a", 32'(next_angle), 4);
        chk("turn_r_x", 32'(next_pos_x), 500);
        chk("turn_r_reqs", 32'(req_count), 0);
        chk("turn_r_lat", 32'(lat), 3);
        idle(12);
        set_keys(1, 1, 0, 0);
        run_start("turn_rl", lat);
        chk("turn_rl_a", 32'(next_angle), 250);
        idle(12);
        set_pose(500, 600, 5, 40, 20);
        set_keys(0, 1, 0, 0);
        run_start("turn_l", lat);
        chk("turn_l_a", 32'(next_angle), 251);

        // Backward past x=0: x out of bounds, y slides to 980.
        idle(12);
        set_pose(10, 1000, 0, 40, 20);
        set_keys(0, 0, 0, 1);
        run_start("oob_lo", lat);
        chk("oob_lo_x", 32'(next_pos_x), 10);
        chk("oob_lo_y", 32'(next_pos_y), 980);
        chk("oob_lo_reqs", 32'(req_count), 1);
        chk("oob_lo_gx", 32'(grid_x), 0);
        chk("oob_lo_gy", 32'(grid_y), 3);

        // Landing exactly on the last legal x, then one past it.
        idle(12);
        set_pose(16343, 500, 0, 40, 0);
        set_keys(0, 0, 1, 0);
        run_start("edge", lat);
        chk("edge_x", 32'(next_pos_x), 16383);
        chk("edge_y", 32'(next_pos_y), 500);
        chk("edge_reqs", 32'(req_count), 1);
        chk("edge_gx", 32'(grid_x), 63);
        chk("edge_gy", 32'(grid_y), 1);
        idle(12);
        set_pose(16380, 500, 0, 40, 0);
        run_start("oob_hi", lat);
        chk("oob_hi_x", 32'(next_pos_x), 16380);
        chk("oob_hi_reqs", 32'(req_count), 0);

        // Forward and backward together cancel.
        idle(12);
        set_pose(1000, 1000, 0, 40, 20);
        set_keys(0, 0, 1, 1);
        run_start("cancel", lat);
        chk("cancel_x", 32'(next_pos_x), 1000);
        chk("cancel_y", 32'(next_pos_y), 1000);
        chk("cancel_reqs", 32'(req_count), 0);

        // Tick divider of 8 with back-to-back starts: process, skip, skip, process.
        idle(12);
        set_pose(2000, 3000, 100, 40, 20);
        set_keys(1, 0, 0, 0);
        run_start("div1", lat);
        chk("div1_a", 32'(next_angle), 110);
        chk("div1_lat", 32'(lat), 3);
        run_start("div2", lat);
        chk("div2_a", 32'(next_angle), 100);
        chk("div2_x", 32'(next_pos_x), 2000);
        chk("div2_lat", 32'(lat), 2);
        run_start("div3", lat);
        chk("div3_a", 32'(next_angle), 100);
        chk("div3_lat", 32'(lat), 2);
        run_start("div4", lat);
        chk("div4_a", 32'(next_angle), 110);
        chk("div4_lat", 32'(lat), 3);

        // Reset while a grid answer is outstanding.
        idle(12);
        grid_lat = 5;
        set_pose(1000, 1000, 0, 40, 20);
        set_keys(0, 0, 1, 0);
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < 20 && !grid_req; i++) begin
            @(posedge clock);
            #1;
        end
        chk("mid_req_seen", 32'(grid_req), 1);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(grid_req), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_gx", 32'(grid_x), 0);
        chk("mid_rst_nx", 32'(next_pos_x), 0);
        chk("mid_rst_na", 32'(next_angle), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        idle(12);
        grid_lat = 1;
        run_start("after_rst", lat);
        chk("after_rst_x", 32'(next_pos_x), 1040);
        chk("after_rst_y", 32'(next_pos_y), 1020);
        chk("after_rst_reqs", 32'(req_count), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
